// File: rtl/demultiplexor_tdm.sv
// Four-slot time-division demultiplexer: collects sync-tagged frames into shadow
// registers and publishes them atomically. Define DEMUX_TIMEOUT_EN to abort stalled frames.
module demultiplexor_tdm #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic [WIDTH-1:0] i_Dato,
    input  logic             i_Valido,
    input  logic             i_Sync,
    output logic [WIDTH-1:0] o_Datos_0,
    output logic [WIDTH-1:0] o_Datos_1,
    output logic [WIDTH-1:0] o_Datos_2,
    output logic [WIDTH-1:0] o_Datos_3,
    output logic [1:0]       o_Sel,
    output logic             o_Listo,
    output logic             o_Error
);

    typedef enum logic {HUNT = 1'b0, COLLECT = 1'b1} state_t;

    state_t                  state, state_nxt;
    logic [1:0]              slot, slot_nxt;
    logic [2:0][WIDTH-1:0]   shadow, shadow_nxt;
    logic [3:0][WIDTH-1:0]   datos, datos_nxt;
    logic                    listo, listo_nxt;
    logic                    error, error_nxt;
    logic                    timeout_hit;

`ifdef DEMUX_TIMEOUT_EN
    // Counter only needs to reach TIMEOUT-1; the edge that would reach TIMEOUT aborts instead.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;

    always_comb begin
        idle_cnt_nxt = '0;
        timeout_hit  = 1'b0;
        if (state == COLLECT && !i_Valido) begin
            if (idle_cnt == CNT_W'(TIMEOUT - 1))
                timeout_hit = 1'b1;
            else
                idle_cnt_nxt = idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) idle_cnt <= '0;
        else       idle_cnt <= idle_cnt_nxt;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        slot_nxt   = slot;
        shadow_nxt = shadow;
        datos_nxt  = datos;
        listo_nxt  = 1'b0;
        error_nxt  = 1'b0;
        case (state)
            HUNT: begin
                // Words without sync while hunting are dropped silently.
                if (i_Valido && i_Sync) begin
                    shadow_nxt[0] = i_Dato;
                    slot_nxt      = 2'd1;
                    state_nxt     = COLLECT;
                end
            end
            COLLECT: begin
                if (i_Valido) begin
                    if (i_Sync) begin
                        // Early sync: drop the partial frame, restart on this word.
                        error_nxt     = 1'b1;
                        shadow_nxt[0] = i_Dato;
                        slot_nxt      = 2'd1;
                    end else if (slot == 2'd3) begin
                        datos_nxt = {i_Dato, shadow[2], shadow[1], shadow[0]};
                        listo_nxt = 1'b1;
                        slot_nxt  = 2'd0;
                        state_nxt = HUNT;
                    end else begin
                        case (slot)
                            2'd1:    shadow_nxt[1] = i_Dato;
                            default: shadow_nxt[2] = i_Dato;
                        endcase
                        slot_nxt = slot + 2'd1;
                    end
                end else if (timeout_hit) begin
                    error_nxt = 1'b1;
                    slot_nxt  = 2'd0;
                    state_nxt = HUNT;
                end
            end
            default: begin
                slot_nxt  = 2'd0;
                state_nxt = HUNT;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state  <= HUNT;
            slot   <= 2'd0;
            shadow <= '0;
            datos  <= '0;
            listo  <= 1'b0;
            error  <= 1'b0;
        end else begin
            state  <= state_nxt;
            slot   <= slot_nxt;
            shadow <= shadow_nxt;
            datos  <= datos_nxt;
            listo  <= listo_nxt;
            error  <= error_nxt;
        end
    end

    // slot is held at 0 while hunting, so it doubles as the published selector.
    assign o_Sel     = slot;
    assign o_Datos_0 = datos[0];
    assign o_Datos_1 = datos[1];
    assign o_Datos_2 = datos[2];
    assign o_Datos_3 = datos[3];
    assign o_Listo   = listo;
    assign o_Error   = error;

endmodule

// File: tb/tb_demultiplexor_tdm.sv
// Table-driven bench for demultiplexor_tdm with a frame scoreboard popped on o_Listo.
module tb_demultiplexor_tdm;

    localparam int W = 4;
`ifdef DEMUX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         i_Clk, i_Rst, i_Valido, i_Sync;
    logic [W-1:0] i_Dato;
    logic [W-1:0] o_Datos_0, o_Datos_1, o_Datos_2, o_Datos_3;
    logic [1:0]   o_Sel;
    logic         o_Listo, o_Error;

    demultiplexor_tdm #(.WIDTH(W), .TIMEOUT(15)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Dato(i_Dato), .i_Valido(i_Valido), .i_Sync(i_Sync),
        .o_Datos_0(o_Datos_0), .o_Datos_1(o_Datos_1), .o_Datos_2(o_Datos_2),
        .o_Datos_3(o_Datos_3), .o_Sel(o_Sel), .o_Listo(o_Listo), .o_Error(o_Error)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic        v;
        logic        s;
        logic [3:0]  d;
        logic [1:0]  sel;
        logic        listo;
        logic        err;
        logic [15:0] datos;
    } vec_t;

    vec_t        tbl_a[$];
    vec_t        tbl_b[$];
    logic [15:0] sb[$];
    int          passed = 0;
    int          total  = 0;

    function automatic logic [15:0] datos_act();
        return {o_Datos_3, o_Datos_2, o_Datos_1, o_Datos_0};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(logic v, logic s, logic [3:0] d, logic [1:0] sel,
                                logic listo, logic err, logic [15:0] datos);
        vec_t x;
        x.v = v; x.s = s; x.d = d; x.sel = sel; x.listo = listo; x.err = err; x.datos = datos;
        return x;
    endfunction

    task automatic apply(input vec_t x, input string tag, input int idx);
        i_Valido = x.v;
        i_Sync   = x.s;
        i_Dato   = x.d;
        if (x.listo) sb.push_back(x.datos);
        @(posedge i_Clk);
        #1;
        check($sformatf("%s%0d sel", tag, idx),   16'(o_Sel),   16'(x.sel));
        check($sformatf("%s%0d listo", tag, idx), 16'(o_Listo), 16'(x.listo));
        check($sformatf("%s%0d error", tag, idx), 16'(o_Error), 16'(x.err));
        check($sformatf("%s%0d datos", tag, idx), datos_act(),  x.datos);
    endtask

    // Scoreboard: every o_Listo pulse must match the frame queued when its last word was driven.
    always @(negedge i_Clk) begin
        if (!i_Rst) begin
            check("listo_error_exclusive", 16'(o_Listo & o_Error), 16'h0);
            if (o_Listo) check("sb_frame", datos_act(), (sb.size() > 0) ? sb.pop_front() : 16'hxxxx);
        end
    end

    initial begin
        // basic frame
        tbl_a.push_back(mk(1, 1, 4'h1, 2'd1, 0, 0, 16'h0000));
        tbl_a.push_back(mk(1, 0, 4'h2, 2'd2, 0, 0, 16'h0000));
        tbl_a.push_back(mk(1, 0, 4'h4, 2'd3, 0, 0, 16'h0000));
        tbl_a.push_back(mk(1, 0, 4'h8, 2'd0, 1, 0, 16'h8421));
        // gapped frame, then back-to-back frame
        tbl_a.push_back(mk(1, 1, 4'h3, 2'd1, 0, 0, 16'h8421));
        tbl_a.push_back(mk(0, 0, 4'h0, 2'd1, 0, 0, 16'h8421));
        tbl_a.push_back(mk(0, 1, 4'hF, 2'd1, 0, 0, 16'h8421));
        tbl_a.push_back(mk(1, 0, 4'h5, 2'd2, 0, 0, 16'h8421));
        tbl_a.push_back(mk(0, 0, 4'h0, 2'd2, 0, 0, 16'h8421));
        tbl_a.push_back(mk(0, 0, 4'h0, 2'd2, 0, 0, 16'h8421));
        tbl_a.push_back(mk(1, 0, 4'h6, 2'd3, 0, 0, 16'h8421));
        tbl_a.push_back(mk(0, 0, 4'h0, 2'd3, 0, 0, 16'h8421));
        tbl_a.push_back(mk(0, 0, 4'h0, 2'd3, 0, 0, 16'h8421));
        tbl_a.push_back(mk(1, 0, 4'h9, 2'd0, 1, 0, 16'h9653));
        tbl_a.push_back(mk(1, 1, 4'hF, 2'd1, 0, 0, 16'h9653));
        tbl_a.push_back(mk(1, 0, 4'hE, 2'd2, 0, 0, 16'h9653));
        tbl_a.push_back(mk(1, 0, 4'hD, 2'd3, 0, 0, 16'h9653));
        tbl_a.push_back(mk(1, 0, 4'hC, 2'd0, 1, 0, 16'hCDEF));
        // hunt discard, then early sync
        tbl_a.push_back(mk(1, 0, 4'h7, 2'd0, 0, 0, 16'hCDEF));
        tbl_a.push_back(mk(1, 0, 4'h7, 2'd0, 0, 0, 16'hCDEF));
        tbl_a.push_back(mk(1, 1, 4'h1, 2'd1, 0, 0, 16'hCDEF));
        tbl_a.push_back(mk(1, 0, 4'h2, 2'd2, 0, 0, 16'hCDEF));
        tbl_a.push_back(mk(1, 1, 4'hA, 2'd1, 0, 1, 16'hCDEF));
        tbl_a.push_back(mk(1, 0, 4'hB, 2'd2, 0, 0, 16'hCDEF));
        tbl_a.push_back(mk(1, 0, 4'hC, 2'd3, 0, 0, 16'hCDEF));
        tbl_a.push_back(mk(1, 0, 4'hD, 2'd0, 1, 0, 16'hDCBA));
        // stall: 1(sync),2 then 15 idle cycles
        tbl_a.push_back(mk(1, 1, 4'h1, 2'd1, 0, 0, 16'hDCBA));
        tbl_a.push_back(mk(1, 0, 4'h2, 2'd2, 0, 0, 16'hDCBA));
        for (int i = 0; i < 14; i++) tbl_a.push_back(mk(0, 0, 4'h0, 2'd2, 0, 0, 16'hDCBA));
        tbl_a.push_back(mk(0, 0, 4'h0, TO_EN ? 2'd0 : 2'd2, 0, TO_EN, 16'hDCBA));
        tbl_a.push_back(mk(1, 0, 4'h0, TO_EN ? 2'd0 : 2'd3, 0, 0, 16'hDCBA));
        // accepted word on the would-be timeout edge wins
        tbl_a.push_back(mk(1, 1, 4'h1, 2'd1, 0, !TO_EN, 16'hDCBA));
        for (int i = 0; i < 14; i++) tbl_a.push_back(mk(0, 0, 4'h0, 2'd1, 0, 0, 16'hDCBA));
        tbl_a.push_back(mk(1, 0, 4'h2, 2'd2, 0, 0, 16'hDCBA));
        tbl_a.push_back(mk(0, 0, 4'h0, 2'd2, 0, 0, 16'hDCBA));
        // after mid-frame reset: leftover words without sync, then a clean frame
        tbl_b.push_back(mk(1, 0, 4'h4, 2'd0, 0, 0, 16'h0000));
        tbl_b.push_back(mk(1, 0, 4'h8, 2'd0, 0, 0, 16'h0000));
        tbl_b.push_back(mk(1, 1, 4'h1, 2'd1, 0, 0, 16'h0000));
        tbl_b.push_back(mk(1, 0, 4'h2, 2'd2, 0, 0, 16'h0000));
        tbl_b.push_back(mk(1, 0, 4'h3, 2'd3, 0, 0, 16'h0000));
        tbl_b.push_back(mk(1, 0, 4'h4, 2'd0, 1, 0, 16'h4321));

        i_Rst = 1'b1; i_Valido = 1'b0; i_Sync = 1'b0; i_Dato = '0;
        #2;
        check("reset sel",   16'(o_Sel),   16'h0);
        check("reset listo", 16'(o_Listo), 16'h0);
        check("reset error", 16'(o_Error), 16'h0);
        check("reset datos", datos_act(),  16'h0000);
        @(posedge i_Clk); #1;
        i_Rst = 1'b0;

        for (int i = 0; i < tbl_a.size(); i++) apply(tbl_a[i], "a", i);

        // Reset mid-frame, between edges: outputs must clear without a clock.
        #2;
        i_Rst = 1'b1;
        #1;
        check("async_rst sel",   16'(o_Sel),   16'h0);
        check("async_rst listo", 16'(o_Listo), 16'h0);
        check("async_rst error", 16'(o_Error), 16'h0);
        check("async_rst datos", datos_act(),  16'h0000);
        @(posedge i_Clk); #1;
        i_Rst = 1'b0;

        for (int i = 0; i < tbl_b.size(); i++) apply(tbl_b[i], "b", i);

        i_Valido = 1'b0;
        @(posedge i_Clk); #1;
        @(negedge i_Clk); #1;
        check("sb_drained", 16'(sb.size()), 16'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
